// File: rtl/coin_input_conditioner.sv
// Conditions four bouncy coin/selection buttons into single-cycle, spaced event pulses.
// Path per input: 2-flop sync -> debounce -> pending flag -> fixed-priority arbiter with gap timer.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic joltRaw,
  input  logic buzzWaterRaw,
  input  logic nickelRaw,
  input  logic dimeRaw,
  output logic jolt,
  output logic buzzWater,
  output logic nickel,
  output logic dime,
  output logic busy
);

  localparam logic [15:0] CntMax  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  GapLoad = 4'(GAP_CYCLES);

  // Bit order doubles as arbitration priority: 0 = dime (highest) .. 3 = buzzWater.
  logic [3:0]  rawVec;
  logic [3:0]  sync1Q, sync2Q;
  logic [3:0]  stableQ, stableD;
  logic [3:0]  rise;
  logic [3:0]  pendingQ, pendingD;
  logic [3:0]  agedQ, agedD;
  logic [3:0]  grant;
  logic [3:0]  pulseQ;
  logic [15:0] cntQ [4];
  logic [15:0] cntD [4];
  logic [3:0]  gapQ, gapD;
  logic        busyQ, busyD;

  assign rawVec = {buzzWaterRaw, joltRaw, nickelRaw, dimeRaw};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stableD[i] = stableQ[i];
      cntD[i]    = '0;
      if (sync2Q[i] != stableQ[i]) begin
        if (cntQ[i] == CntMax) begin
          stableD[i] = sync2Q[i];
        end else begin
          cntD[i] = cntQ[i] + 16'd1;
        end
      end
    end
  end

  assign rise = stableD & ~stableQ;

  // Only flags that have been pending for a full cycle (aged) compete, so a flag set on a
  // firing edge waits for the next arbitration opportunity.
  always_comb begin
    grant = '0;
    gapD  = gapQ;
    if (gapQ == 4'd0) begin
      if (agedQ[0]) begin
        grant = 4'b0001;
      end else if (agedQ[1]) begin
        grant = 4'b0010;
      end else if (agedQ[2]) begin
        grant = 4'b0100;
      end else if (agedQ[3]) begin
        grant = 4'b1000;
      end
      if (grant != 4'd0) begin
        gapD = GapLoad;
      end
    end else begin
      gapD = gapQ - 4'd1;
    end
  end

  assign pendingD = (pendingQ & ~grant) | rise;
  assign agedD    = pendingQ & pendingD & ~grant;
  assign busyD    = (|pendingQ) | (gapQ != 4'd0);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1Q   <= '0;
      sync2Q   <= '0;
      stableQ  <= '0;
      pendingQ <= '0;
      agedQ    <= '0;
      pulseQ   <= '0;
      gapQ     <= '0;
      busyQ    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cntQ[i] <= '0;
      end
    end else begin
      sync1Q   <= rawVec;
      sync2Q   <= sync1Q;
      stableQ  <= stableD;
      pendingQ <= pendingD;
      agedQ    <= agedD;
      pulseQ   <= grant;
      gapQ     <= gapD;
      busyQ    <= busyD;
      for (int i = 0; i < 4; i++) begin
        cntQ[i] <= cntD[i];
      end
    end
  end

  assign dime      = pulseQ[0];
  assign nickel    = pulseQ[1];
  assign jolt      = pulseQ[2];
  assign buzzWater = pulseQ[3];
  assign busy      = busyQ;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner: a run-length/timestamp model checked every
// cycle, plus literal pulse timing expectations for the directed scenarios.
module tb_coin_input_conditioner;

  localparam int D = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic joltRaw = 1'b0, buzzWaterRaw = 1'b0, nickelRaw = 1'b0, dimeRaw = 1'b0;
  logic jolt, buzzWater, nickel, dime, busy;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .GAP_CYCLES     (G)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .joltRaw     (joltRaw),
    .buzzWaterRaw(buzzWaterRaw),
    .nickelRaw   (nickelRaw),
    .dimeRaw     (dimeRaw),
    .jolt        (jolt),
    .buzzWater   (buzzWater),
    .nickel      (nickel),
    .dime        (dime),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int edgeN   = 0;

  // Model state, index 0 = dime, 1 = nickel, 2 = jolt, 3 = buzzWater.
  logic [3:0] mR1, mR2, mStab, mPend;
  int         mRun [4];
  int         mPendEdge [4];
  int         mNextAllowed;
  logic [3:0] expOut;
  logic       expBusy;

  int pulseCount [4];
  int lastPulse  [4];

  task automatic check(input string name, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edgeN);
  endtask

  task automatic modelEdge();
    logic [3:0] rawNow;
    logic       sv;
    int         fire;
    rawNow = {buzzWaterRaw, joltRaw, nickelRaw, dimeRaw};
    if (!resetN) begin
      mR1 = '0; mR2 = '0; mStab = '0; mPend = '0; mNextAllowed = 0;
      for (int i = 0; i < 4; i++) begin mRun[i] = 0; mPendEdge[i] = 0; end
      expOut = '0; expBusy = 1'b0;
      return;
    end
    expBusy = (|mPend) || (edgeN < mNextAllowed);
    fire = -1;
    if (edgeN >= mNextAllowed) begin
      for (int i = 0; i < 4; i++)
        if (fire < 0 && mPend[i] && mPendEdge[i] <= edgeN - 2) fire = i;
    end
    expOut = '0;
    if (fire >= 0) begin
      expOut[fire] = 1'b1;
      mPend[fire] = 1'b0;
      mNextAllowed = edgeN + G + 1;
    end
    for (int i = 0; i < 4; i++) begin
      sv = mR2[i];
      mR2[i] = mR1[i];
      mR1[i] = rawNow[i];
      if (sv != mStab[i]) begin
        mRun[i]++;
        if (mRun[i] == D) begin
          mStab[i] = sv;
          mRun[i] = 0;
          if (sv) begin
            if (!mPend[i]) mPendEdge[i] = edgeN;
            mPend[i] = 1'b1;
          end
        end
      end else begin
        mRun[i] = 0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] got;
    @(posedge clk);
    edgeN++;
    modelEdge();
    #1;
    got = {buzzWater, jolt, nickel, dime};
    for (int i = 0; i < 4; i++) begin
      if (got[i]) begin
        pulseCount[i]++;
        lastPulse[i] = edgeN;
      end
    end
    check("cycle outputs {busy,buzz,jolt,nickel,dime}", int'({busy, got}),
          int'({expBusy, expOut}));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int e0, c0, c1;

  initial begin
    for (int i = 0; i < 4; i++) begin pulseCount[i] = 0; lastPulse[i] = -1; end

    // Reset state.
    steps(2);
    check("reset outputs", int'({busy, buzzWater, jolt, nickel, dime}), 0);
    resetN = 1'b1;
    steps(3);

    // Clean press: nickel pulse after edge 7, busy 6..9.
    nickelRaw = 1'b1;
    e0 = edgeN + 1;
    steps(6);
    check("clean busy at edge 5", int'(busy), 0);
    step();
    check("clean busy at edge 6", int'(busy), 1);
    steps(3);
    check("clean busy at edge 9", int'(busy), 1);
    step();
    check("clean busy at edge 10", int'(busy), 0);
    check("clean nickel latency", lastPulse[1] - e0, 7);
    check("clean nickel count", pulseCount[1], 1);
    nickelRaw = 1'b0;
    steps(15);

    // Bounce on dime: 1,1,0, then held.
    c0 = pulseCount[0];
    dimeRaw = 1'b1; steps(2);
    dimeRaw = 1'b0; step();
    dimeRaw = 1'b1;
    e0 = edgeN + 1;
    steps(20);
    check("bounce dime count", pulseCount[0] - c0, 1);
    check("bounce dime latency", lastPulse[0] - e0, 7);
    dimeRaw = 1'b0;
    steps(15);

    // Simultaneous press: dime, nickel, jolt, buzzWater spaced GAP+1 apart.
    {buzzWaterRaw, joltRaw, nickelRaw, dimeRaw} = 4'hF;
    e0 = edgeN + 1;
    steps(25);
    check("simul dime edge",   lastPulse[0] - e0, 7);
    check("simul nickel edge", lastPulse[1] - e0, 10);
    check("simul jolt edge",   lastPulse[2] - e0, 13);
    check("simul buzz edge",   lastPulse[3] - e0, 16);
    check("simul idle busy", int'(busy), 0);
    {buzzWaterRaw, joltRaw, nickelRaw, dimeRaw} = 4'h0;
    steps(15);

    // Hold then release jolt.
    c0 = pulseCount[2];
    joltRaw = 1'b1; steps(100);
    c1 = pulseCount[2];
    joltRaw = 1'b0; steps(100);
    check("hold jolt count", c1 - c0, 1);
    check("release no jolt", pulseCount[2] - c1, 0);
    check("hold release busy", int'(busy), 0);

    // Reset mid-debounce on buzzWater.
    c0 = pulseCount[3];
    buzzWaterRaw = 1'b1;
    steps(4);
    resetN = 1'b0; step();
    check("rst mid no early buzz", pulseCount[3] - c0, 0);
    resetN = 1'b1;
    e0 = edgeN + 1;
    steps(20);
    check("rst mid buzz count", pulseCount[3] - c0, 1);
    check("rst mid buzz latency", lastPulse[3] - e0, 7);
    buzzWaterRaw = 1'b0;
    steps(15);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive cycles a synchronized input must differ from its debounced value before it is accepted; legal range is 1..65535.
REQ-002 Parameter GAP_CYCLES, default 2, is the number of idle cycles forced between any two output pulses; legal range is 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetN  input  1  reset; synchronous, active-low.
REQ-005 joltRaw, buzzWaterRaw, nickelRaw, dimeRaw  input  1 each  asynchronous, bouncy push-button levels; active-high.
REQ-006 jolt, buzzWater, nickel, dime  output  1 each  registered single-cycle event pulses for the vending controller.
REQ-007 busy  output  1  high while any event is pending or the gap timer is nonzero.

Function
REQ-008 Each raw input SHALL pass through its own 2-flop synchronizer; no other logic shall sample a raw input.
REQ-009 Each input SHALL have a debounced register `stable` and a 16-bit counter.
- When the synchronized value equals `stable`, the counter clears.
- When it differs and the counter is below DEBOUNCE_CYCLES-1, the counter increments.
- When it differs and the counter equals DEBOUNCE_CYCLES-1, `stable` takes the synchronized value and the counter clears.
REQ-010 Any single-cycle return to the `stable` value SHALL restart that input's count from zero.
REQ-011 A 0->1 update of `stable` SHALL set that input's pending flag on the same edge; 1->0 updates SHALL produce no event.
REQ-012 A press arriving while the same input's pending flag is already set SHALL be merged: the flag stays set and only one pulse is issued.
REQ-013 Arbiter: on an edge where the gap timer is 0 and at least one pending flag is set, the module SHALL do all of the following on that edge:
- assert exactly one output for that cycle;
- clear the corresponding pending flag;
- load the gap timer with GAP_CYCLES.
REQ-014 Arbitration priority SHALL be fixed, highest first: dime, nickel, jolt, buzzWater.
REQ-015 On every other edge, a nonzero gap timer SHALL decrement by 1, and all four outputs SHALL be 0.
REQ-016 Consecutive pulses SHALL therefore be spaced GAP_CYCLES+1 cycles apart; with GAP_CYCLES=0, pulses may occur on back-to-back cycles.
REQ-017 At most one of jolt, buzzWater, nickel, dime SHALL be high in any cycle, and each pulse SHALL last exactly one cycle.
REQ-018 Latency: a raw rising level first captured at edge 0 and held SHALL produce its output pulse after edge DEBOUNCE_CYCLES+3, when no other event competes and the gap timer is 0.
REQ-019 A pending flag being set on the same edge that the arbiter fires SHALL be served no earlier than the next arbitration opportunity.
REQ-020 busy SHALL be the registered OR of all pending flags and (gap timer != 0).

Reset
REQ-021 While resetN is low at a clock edge, all synchronizer flops, stable registers, counters, pending flags and the gap timer SHALL clear to 0, and all outputs, including busy, SHALL be 0 after that edge.
REQ-022 An input held high through reset SHALL be treated as a new press after reset releases; its pulse follows the REQ-018 latency, counted from the first edge with resetN high.
REQ-023 Reset asserted mid-debounce or mid-gap SHALL discard all partial progress; no pulse from before the reset shall appear after it.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=2)
REQ-024 Clean press: nickelRaw rises before edge 0 and is held -> nickel=1 only in the cycle following edge 7; busy=1 from edge 6 through the cycle following edge 9, then 0.
REQ-025 Bounce: dimeRaw high 2 cycles, low 1 cycle, then held high -> no pulse during the bounce; exactly one dime pulse, 7 edges after the final rising sample.
REQ-026 Simultaneous: all four raw inputs rise before the same edge and are held -> pulses in the order dime, nickel, jolt, buzzWater at cycles t, t+3, t+6, t+9; never two outputs high at once.
REQ-027 Hold/release: joltRaw held 100 cycles, then low for 100 cycles -> exactly one jolt pulse; no pulse on release; busy returns to 0.
REQ-028 Reset mid-debounce: buzzWaterRaw held high; resetN low for one edge, 4 edges after the input rose -> no pulse before reset; exactly one buzzWater pulse 7 edges after resetN returns high.
